// File: rtl/vga_scaler_scheduler.sv
// VGA read-side scheduler: 640x480@60 timing, ping-pong NES line buffer fed
// from a first-word-fall-through FIFO, 2x horizontal / 2x vertical scaling.
module vga_scaler_scheduler #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int NES_WIDTH = 256,
   parameter int X_OFFSET  = 64
) (
   input  logic        i_clk_25mhz,
   input  logic        i_reset_n,
   input  logic        i_fifo_empty,
   input  logic [23:0] i_fifo_rgb,
   output logic        o_fifo_rd_en,
   output logic        o_vga_hsync,
   output logic        o_vga_vsync,
   output logic        o_vga_de,
   output logic [23:0] o_vga_rgb,
   output logic        o_frame_start,
   output logic        o_underflow
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int AW      = $clog2(NES_WIDTH);
   localparam int CW      = AW + 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] X_BEG      = HW'(X_OFFSET);
   localparam logic [HW-1:0] X_END      = HW'(X_OFFSET + 2 * NES_WIDTH);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_SWAP_END = VW'(V_ACTIVE - 1);
   localparam logic [CW-1:0] FILL_FULL  = CW'(NES_WIDTH);

   typedef enum logic {S_PRIME = 1'b0, S_RUN = 1'b1} state_t;

   state_t        r_state;
   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic          r_fill_bank;
   logic          r_disp_bank;
   logic [CW-1:0] r_fill_count;
   logic          r_underflow;

   logic [23:0]   r_line_mem [0:2*NES_WIDTH-1];
   logic [23:0]   r_rd_data_p1;
   logic          r_hs_p1, r_vs_p1, r_de_p1, r_pix_p1, r_fs_p1;

   logic          w_h_wrap, w_v_wrap, w_fill_full, w_swap_pt, w_do_swap, w_pop;
   logic          w_active;
   logic [AW-1:0] w_rd_idx;

   assign w_h_wrap    = (r_h == H_LAST);
   assign w_v_wrap    = (r_v == V_LAST);
   assign w_fill_full = (r_fill_count == FILL_FULL);
   // Swap after every second active row, and at the end of the frame so row 0 gets a fresh line.
   assign w_swap_pt   = w_h_wrap && ((r_v[0] && (r_v < V_SWAP_END)) || w_v_wrap);
   // While priming only the frame-end swap point may start display.
   assign w_do_swap   = w_swap_pt && w_fill_full && ((r_state == S_RUN) || w_v_wrap);
   // Backpressure: no pops while the fill bank holds a complete line.
   assign w_pop       = i_reset_n && !i_fifo_empty && !w_fill_full;
   assign o_fifo_rd_en = w_pop;

   assign w_active = (r_h < H_ACT_END) && (r_v < V_ACT_END);
   assign w_rd_idx = AW'((r_h - X_BEG) >> 1);
   assign o_underflow = r_underflow;

   // Horizontal / vertical raster counters.
   always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_h_wrap) begin
         r_h <= '0;
         r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end else begin
         r_h <= r_h + 1'b1;
      end
   end

   // Prime/run FSM with bank swapping, fill counting and sticky underflow.
   always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= S_PRIME;
         r_fill_bank  <= 1'b0;
         r_disp_bank  <= 1'b1;
         r_fill_count <= '0;
         r_underflow  <= 1'b0;
      end else begin
         if (w_do_swap) begin
            r_disp_bank  <= r_fill_bank;
            r_fill_bank  <= ~r_fill_bank;
            r_fill_count <= '0;
            r_state      <= S_RUN;
         end else if (w_pop) begin
            r_fill_count <= r_fill_count + 1'b1;
         end
         if ((r_state == S_RUN) && w_swap_pt && !w_fill_full) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Line buffer write port: popped pixels land in the fill bank.
   always_ff @(posedge i_clk_25mhz) begin
      if (w_pop) begin
         r_line_mem[{r_fill_bank, r_fill_count[AW-1:0]}] <= i_fifo_rgb;
      end
   end

   // Stage p1: synchronous line buffer read of the display bank.
   always_ff @(posedge i_clk_25mhz) begin
      r_rd_data_p1 <= r_line_mem[{r_disp_bank, w_rd_idx}];
   end

   // Stage p1: timing and pixel-select decode aligned with the RAM read.
   always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_hs_p1  <= 1'b1;
         r_vs_p1  <= 1'b1;
         r_de_p1  <= 1'b0;
         r_pix_p1 <= 1'b0;
         r_fs_p1  <= 1'b0;
      end else begin
         r_hs_p1  <= !((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
         r_vs_p1  <= !((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));
         r_de_p1  <= w_active;
         r_pix_p1 <= (r_state == S_RUN) && w_active && (r_h >= X_BEG) && (r_h < X_END);
         r_fs_p1  <= (r_state == S_RUN) && (r_h == '0) && (r_v == '0);
      end
   end

   // Stage p2: registered VGA outputs; borders and priming output black.
   always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_vga_hsync   <= 1'b1;
         o_vga_vsync   <= 1'b1;
         o_vga_de      <= 1'b0;
         o_vga_rgb     <= '0;
         o_frame_start <= 1'b0;
      end else begin
         o_vga_hsync   <= r_hs_p1;
         o_vga_vsync   <= r_vs_p1;
         o_vga_de      <= r_de_p1;
         o_vga_rgb     <= r_pix_p1 ? r_rd_data_p1 : 24'h0;
         o_frame_start <= r_fs_p1;
      end
   end
endmodule

// File: tb/tb_vga_scaler_scheduler.sv
// Bench for vga_scaler_scheduler: reduced-raster instance against a line-level
// reference model, plus a full-size instance for the 640x480 timing.
module tb_vga_scaler_scheduler;
   localparam int HA = 40, HFP = 2, HS = 4, HBP = 2;
   localparam int VA = 12, VFP = 2, VS = 2, VBP = 2;
   localparam int NW = 16, XO = 4;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, fifo_empty;
   logic [23:0] fifo_rgb;
   logic        o_rd_en, o_hs, o_vs, o_de, o_fs, o_uf;
   logic [23:0] o_rgb;

   logic        d_rst_n, d_empty;
   logic [23:0] d_rgb_in;
   logic        d_rd_en, d_hs, d_vs, d_de, d_fs, d_uf;
   logic [23:0] d_rgb;

   vga_scaler_scheduler #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .NES_WIDTH(NW), .X_OFFSET(XO)
   ) u_dut (
      .i_clk_25mhz(clk), .i_reset_n(rst_n), .i_fifo_empty(fifo_empty),
      .i_fifo_rgb(fifo_rgb), .o_fifo_rd_en(o_rd_en), .o_vga_hsync(o_hs),
      .o_vga_vsync(o_vs), .o_vga_de(o_de), .o_vga_rgb(o_rgb),
      .o_frame_start(o_fs), .o_underflow(o_uf)
   );

   vga_scaler_scheduler u_full (
      .i_clk_25mhz(clk), .i_reset_n(d_rst_n), .i_fifo_empty(d_empty),
      .i_fifo_rgb(d_rgb_in), .o_fifo_rd_en(d_rd_en), .o_vga_hsync(d_hs),
      .o_vga_vsync(d_vs), .o_vga_de(d_de), .o_vga_rgb(d_rgb),
      .o_frame_start(d_fs), .o_underflow(d_uf)
   );

   int total = 0;
   int bad   = 0;

   // FIFO contents and feed policy: 0 none, 1 always non-empty, 2 sparse random, 3 starved
   logic [23:0] q[$];
   int          mode;

   // reference model state
   int          m_n;
   bit          m_run, m_uf;
   int          m_fill;
   logic [23:0] m_fillbuf [NW];
   logic [23:0] m_disp    [NW];
   bit          p_hs, p_vs, p_de, p_fs, c_hs, c_vs, c_de, c_fs;
   logic [23:0] p_rgb, c_rgb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void tim(input int n, input int ha, hfp, hs, hbp, va, vfp, vs, vbp,
                               output bit hsv, output bit vsv, output bit de);
      int ht, vt, h, v;
      ht  = ha + hfp + hs + hbp;
      vt  = va + vfp + vs + vbp;
      h   = n % ht;
      v   = (n / ht) % vt;
      hsv = !(h >= ha + hfp && h < ha + hfp + hs);
      vsv = !(v >= va + vfp && v < va + vfp + vs);
      de  = (h < ha) && (v < va);
   endfunction

   function automatic logic [23:0] rnd();
      return 24'($urandom());
   endfunction

   task automatic model_reset();
      m_n = 0; m_run = 0; m_uf = 0; m_fill = 0;
      p_hs = 1; p_vs = 1; p_de = 0; p_fs = 0; p_rgb = '0;
      c_hs = 1; c_vs = 1; c_de = 0; c_fs = 0; c_rgb = '0;
   endtask

   task automatic feed();
      case (mode)
         1: while (q.size() < 4) q.push_back(rnd());
         2: if (q.size() < 6 && $urandom_range(0, 7) == 0) q.push_back(rnd());
         default: ;
      endcase
   endtask

   // One clock: drive FIFO, check pop request, advance model, check outputs.
   task automatic step();
      bit e_rd, full, n_hs, n_vs, n_de, n_fs;
      int h, v;
      logic [23:0] n_rgb;
      feed();
      fifo_empty = (q.size() == 0);
      fifo_rgb   = fifo_empty ? 24'h0 : q[0];
      #1;
      e_rd = rst_n && !fifo_empty && (m_fill < NW);
      chk("rd_en", 32'(o_rd_en), 32'(e_rd));
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         h = m_n % HT;
         v = (m_n / HT) % VT;
         tim(m_n, HA, HFP, HS, HBP, VA, VFP, VS, VBP, n_hs, n_vs, n_de);
         n_fs  = m_run && h == 0 && v == 0;
         n_rgb = (m_run && n_de && h >= XO && h < XO + 2 * NW) ? m_disp[(h - XO) / 2] : 24'h0;
         full  = (m_fill == NW);
         if (h == HT - 1 && ((v % 2 == 1 && v < VA - 1) || v == VT - 1)) begin
            if (full && (m_run || v == VT - 1)) begin
               m_disp = m_fillbuf;
               m_fill = 0;
               m_run  = 1;
            end else if (m_run && !full) begin
               m_uf = 1;
            end
         end
         if (e_rd) begin
            m_fillbuf[m_fill] = q.pop_front();
            m_fill++;
         end
         c_hs = p_hs; c_vs = p_vs; c_de = p_de; c_fs = p_fs; c_rgb = p_rgb;
         p_hs = n_hs; p_vs = n_vs; p_de = n_de; p_fs = n_fs; p_rgb = n_rgb;
         m_n++;
      end
      #1;
      chk("hsync", 32'(o_hs), 32'(c_hs));
      chk("vsync", 32'(o_vs), 32'(c_vs));
      chk("de", 32'(o_de), 32'(c_de));
      chk("rgb", 32'(o_rgb), 32'(c_rgb));
      chk("frame_start", 32'(o_fs), 32'(c_fs));
      chk("underflow", 32'(o_uf), 32'(m_uf));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_hsync"}, 32'(o_hs), 32'd1);
      chk({tag, "_vsync"}, 32'(o_vs), 32'd1);
      chk({tag, "_de"}, 32'(o_de), 32'd0);
      chk({tag, "_rgb"}, 32'(o_rgb), 32'd0);
      chk({tag, "_frame_start"}, 32'(o_fs), 32'd0);
      chk({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
      chk({tag, "_underflow"}, 32'(o_uf), 32'd0);
   endtask

   // Asynchronous reset asserted mid-cycle, held two clocks, released mid-cycle.
   task automatic do_reset(input string tag);
      mode = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      repeat (2) step();
      q.delete();
      rst_n = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      bit e_hs, e_vs, e_de;
      rst_n = 1'b0; fifo_empty = 1'b1; fifo_rgb = '0; mode = 0;
      d_rst_n = 1'b0; d_empty = 1'b1; d_rgb_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;

      // empty FIFO for two frames: timing only, black pixels, no pops
      run(2 * FRAME + 10);

      // line 0 = index ramp, later lines random, FIFO never empty
      do_reset("rst2");
      for (int i = 0; i < NW; i++) q.push_back({8'(i), 8'(i), 8'(i)});
      for (int i = 0; i < 5 * NW; i++) q.push_back(rnd());
      mode = 1;
      run(3 * FRAME + 20);

      // only four lines available, then starved, then resumed
      do_reset("rst3");
      for (int i = 0; i < 4 * NW; i++) q.push_back(rnd());
      mode = 3;
      run(FRAME + 8 * HT + 10);
      chk("underflow_set", 32'(o_uf), 32'd1);
      mode = 1;
      run(FRAME);
      chk("underflow_sticky", 32'(o_uf), 32'd1);

      // reset in the middle of an active row of a running frame
      do_reset("rst4");
      mode = 1;
      run(FRAME + 5 * HT + 20);
      do_reset("rst5");
      mode = 1;
      run(2 * FRAME + 40);

      // sparse random supply, underflow likely
      do_reset("rst6");
      mode = 2;
      run(4 * FRAME);

      // full-size raster: first two rows plus margin with an empty FIFO
      #2;
      chk("full_rst_hsync", 32'(d_hs), 32'd1);
      chk("full_rst_de", 32'(d_de), 32'd0);
      d_rst_n = 1'b1;
      for (int k = 1; k <= 2 * 800 + 10; k++) begin
         @(posedge clk);
         #1;
         if (k < 2) begin
            e_hs = 1; e_vs = 1; e_de = 0;
         end else begin
            tim(k - 2, 640, 16, 96, 48, 480, 10, 2, 33, e_hs, e_vs, e_de);
         end
         chk("full_hsync", 32'(d_hs), 32'(e_hs));
         chk("full_vsync", 32'(d_vs), 32'(e_vs));
         chk("full_de", 32'(d_de), 32'(e_de));
         chk("full_rgb", 32'(d_rgb), 32'd0);
         chk("full_frame_start", 32'(d_fs), 32'd0);
         chk("full_rd_en", 32'(d_rd_en), 32'd0);
         chk("full_underflow", 32'(d_uf), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
